// File: rtl/cache_replacement_ctrl_pkg.sv
// Shared definitions for the cache replacement controller: FSM state type,
// statistics counter width and the saturating counter increment.
package cache_replacement_ctrl_pkg;

  localparam int CNT_WIDTH = 32;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } ctrl_state_e;

  // Statistics counters stick at all-ones instead of wrapping back to zero.
  function automatic cnt_t sat_inc(input cnt_t value);
    return (value == '1) ? value : value + cnt_t'(1);
  endfunction

endpackage

// File: rtl/cache_replacement_ctrl_first_invalid_way.sv
// Priority encoder that picks the lowest-numbered invalid way of a set,
// used as the preferred refill victim before falling back to the LRU way.
module first_invalid_way #(
  parameter int WAYS     = 4,
  parameter int WAY_BITS = 2
) (
  input  logic [WAYS-1:0]     set_valid,
  output logic                found,
  output logic [WAY_BITS-1:0] way
);

  // Scan from the top down so the lowest-numbered empty way wins.
  always_comb begin
    found = 1'b0;
    way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!set_valid[i]) begin
        found = 1'b1;
        way   = WAY_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/cache_replacement_ctrl.sv
// Cache replacement controller: accepts tag-compare results, picks refill
// victims, sequences refills and strobes the external LRU block.
module cache_replacement_ctrl
  import cache_replacement_ctrl_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int INDEX_BITS    = 8,
  parameter int OUTPUT_BITS   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lookup_valid,
  output logic                     lookup_ready,
  input  logic [INDEX_BITS-1:0]    lookup_index,
  input  logic                     lookup_hit,
  input  logic [OUTPUT_BITS-1:0]   lookup_hit_way,
  input  logic [ASSOCIATIVITY-1:0] set_valid,
  output logic [INDEX_BITS-1:0]    line_selector,
  output logic [OUTPUT_BITS-1:0]   referenced_set,
  output logic                     lru_update,
  input  logic [OUTPUT_BITS-1:0]   lru_way,
  output logic                     refill_valid,
  input  logic                     refill_ready,
  output logic [INDEX_BITS-1:0]    refill_index,
  output logic [OUTPUT_BITS-1:0]   refill_way,
  input  logic                     refill_done,
  output logic [CNT_WIDTH-1:0]     hit_count,
  output logic [CNT_WIDTH-1:0]     miss_count
);

  ctrl_state_e             state;
  logic [INDEX_BITS-1:0]   index_q;
  logic [OUTPUT_BITS-1:0]  way_q;
  cnt_t                    hit_cnt;
  cnt_t                    miss_cnt;
  logic                    lookup_ready_q;
  logic                    refill_valid_q;
  logic                    lru_update_q;

  logic                    inv_found;
  logic [OUTPUT_BITS-1:0]  inv_way;
  logic [OUTPUT_BITS-1:0]  victim_way;
  logic                    accept;

  first_invalid_way #(
    .WAYS     (ASSOCIATIVITY),
    .WAY_BITS (OUTPUT_BITS)
  ) u_first_invalid_way (
    .set_valid (set_valid),
    .found     (inv_found),
    .way       (inv_way)
  );

  assign victim_way = inv_found ? inv_way : lru_way;
  assign accept     = lookup_valid && lookup_ready_q;

  // The LRU block must see the incoming index while idle so lru_way is
  // already valid for victim selection in the accepting cycle.
  assign line_selector  = (state == IDLE) ? lookup_index : index_q;
  assign referenced_set = way_q;
  assign refill_index   = index_q;
  assign refill_way     = way_q;
  assign lookup_ready   = lookup_ready_q;
  assign refill_valid   = refill_valid_q;
  assign lru_update     = lru_update_q;
  assign hit_count      = hit_cnt;
  assign miss_count     = miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      index_q        <= '0;
      way_q          <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      lookup_ready_q <= 1'b1;
      refill_valid_q <= 1'b0;
      lru_update_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            index_q        <= lookup_index;
            lookup_ready_q <= 1'b0;
            if (lookup_hit) begin
              way_q        <= lookup_hit_way;
              hit_cnt      <= sat_inc(hit_cnt);
              lru_update_q <= 1'b1;
              state        <= UPDATE;
            end else begin
              way_q          <= victim_way;
              miss_cnt       <= sat_inc(miss_cnt);
              refill_valid_q <= 1'b1;
              state          <= REQ;
            end
          end
        end

        REQ: begin
          // A refill engine may complete in the very cycle it accepts.
          if (refill_ready) begin
            refill_valid_q <= 1'b0;
            if (refill_done) begin
              lru_update_q <= 1'b1;
              state        <= UPDATE;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (refill_done) begin
            lru_update_q <= 1'b1;
            state        <= UPDATE;
          end
        end

        UPDATE: begin
          lru_update_q   <= 1'b0;
          lookup_ready_q <= 1'b1;
          state          <= IDLE;
        end

        default: begin
          lru_update_q   <= 1'b0;
          refill_valid_q <= 1'b0;
          lookup_ready_q <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
